// File: rtl/lock_seq_if.sv
// rtl/lock_seq_if.sv - keypad/store bus between the lock front end and lock_seq_ctrl
interface lock_seq_if;
    logic [1:0] key;
    logic       keypress;
    logic       confirm;
    logic       change_req;
    logic       lock_req;
    logic [2:0] rd_idx;
    logic [1:0] rd_digit;
    logic [2:0] cur_len;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [1:0] wr_digit;
    logic       len_wr;
    logic [2:0] new_len;
    logic       unlocked;
    logic       prog_mode;
    logic       alarm;
    logic [2:0] fail_cnt;

    modport master (
        output key, keypress, confirm, change_req, lock_req, rd_digit, cur_len,
        input  rd_idx, wr_en, wr_idx, wr_digit, len_wr, new_len,
        input  unlocked, prog_mode, alarm, fail_cnt
    );

    modport slave (
        input  key, keypress, confirm, change_req, lock_req, rd_digit, cur_len,
        output rd_idx, wr_en, wr_idx, wr_digit, len_wr, new_len,
        output unlocked, prog_mode, alarm, fail_cnt
    );
endinterface

// File: rtl/lock_seq_ctrl.sv
// rtl/lock_seq_ctrl.sv - digital lock sequencer; LOCK_DEBOUNCE_EN adds per-button debouncers
module lock_seq_ctrl #(
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter int OPEN_CYCLES = 5000,
    parameter int DEB_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    lock_seq_if.slave  bus
);
    localparam int TMAX = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {S_LOCKED, S_OPEN, S_PROGRAM, S_LOCKOUT} state_t;

    // button order: {lock_req, change_req, confirm, keypress}
    logic [3:0] raw, sync1, sync2, lvl, lvl_q, press;
    assign raw = {bus.lock_req, bus.change_req, bus.confirm, bus.keypress};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl_q <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            lvl_q <= lvl;
        end
    end

`ifdef LOCK_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    logic [DW-1:0] deb_cnt [4];
    logic [3:0]    deb_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    deb_lvl[i] <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end
    assign lvl = deb_lvl;
`else
    assign lvl = sync2;
`endif

    assign press = lvl & ~lvl_q;

    logic p_key, p_conf, p_change, p_lock, any_press;
    assign p_key     = press[0];
    assign p_conf    = press[1];
    assign p_change  = press[2];
    assign p_lock    = press[3];
    assign any_press = |press;

    state_t        state;
    logic [2:0]    idx, fail_cnt, wr_idx, new_len;
    logic [1:0]    wr_digit;
    logic          mismatch, wr_en, len_wr, unlocked, prog_mode, alarm;
    logic [TW-1:0] timer;

    logic [2:0] fail_next;
    logic       lock_done, relock;
    assign fail_next = fail_cnt + 3'd1;
    assign lock_done = (timer == TW'(LOCK_CYCLES - 1));
    // lock_req outranks every other press; a press also defeats the idle timeout
    assign relock    = p_lock || (!any_press && (timer == TW'(OPEN_CYCLES - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOCKED;
            idx       <= '0;
            mismatch  <= 1'b0;
            fail_cnt  <= '0;
            timer     <= '0;
            wr_en     <= 1'b0;
            wr_idx    <= '0;
            wr_digit  <= '0;
            len_wr    <= 1'b0;
            new_len   <= '0;
            unlocked  <= 1'b0;
            prog_mode <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            wr_en  <= 1'b0;
            len_wr <= 1'b0;
            case (state)
                S_LOCKED: begin
                    if (p_conf) begin
                        idx      <= '0;
                        mismatch <= 1'b0;
                        timer    <= '0;
                        if (idx == bus.cur_len && !mismatch) begin
                            state    <= S_OPEN;
                            unlocked <= 1'b1;
                            fail_cnt <= '0;
                        end else begin
                            fail_cnt <= fail_next;
                            if (fail_next >= 3'(MAX_FAIL)) begin
                                state <= S_LOCKOUT;
                                alarm <= 1'b1;
                            end
                        end
                    end else if (p_key) begin
                        if (bus.key != bus.rd_digit || idx == 3'd7) mismatch <= 1'b1;
                        if (idx != 3'd7) idx <= idx + 3'd1;
                    end
                end
                S_LOCKOUT: begin
                    if (lock_done) begin
                        state    <= S_LOCKED;
                        alarm    <= 1'b0;
                        fail_cnt <= '0;
                        timer    <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_OPEN, S_PROGRAM: begin
                    if (relock) begin
                        state     <= S_LOCKED;
                        unlocked  <= 1'b0;
                        prog_mode <= 1'b0;
                        idx       <= '0;
                        mismatch  <= 1'b0;
                        timer     <= '0;
                    end else if (any_press) begin
                        timer <= '0;
                        if (state == S_OPEN) begin
                            if (p_change) begin
                                state     <= S_PROGRAM;
                                prog_mode <= 1'b1;
                                idx       <= '0;
                            end
                        end else if (p_conf) begin
                            // an empty entry leaves the stored length untouched
                            len_wr    <= (idx != 3'd0);
                            new_len   <= idx;
                            state     <= S_OPEN;
                            prog_mode <= 1'b0;
                            idx       <= '0;
                        end else if (p_key && idx != 3'd7) begin
                            wr_en    <= 1'b1;
                            wr_idx   <= idx;
                            wr_digit <= bus.key;
                            idx      <= idx + 3'd1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= S_LOCKED;
            endcase
        end
    end

    assign bus.rd_idx    = idx;
    assign bus.wr_en     = wr_en;
    assign bus.wr_idx    = wr_idx;
    assign bus.wr_digit  = wr_digit;
    assign bus.len_wr    = len_wr;
    assign bus.new_len   = new_len;
    assign bus.unlocked  = unlocked;
    assign bus.prog_mode = prog_mode;
    assign bus.alarm     = alarm;
    assign bus.fail_cnt  = fail_cnt;
endmodule

// File: tb/tb_lock_seq_ctrl.sv
// tb/tb_lock_seq_ctrl.sv - directed bench for lock_seq_ctrl with a behavioural password store
module tb_lock_seq_ctrl;
    localparam int LOCK_T = 100;
    localparam int OPEN_T = 150;
    localparam int DEB    = 8;
`ifdef LOCK_DEBOUNCE_EN
    localparam int PD = DEB;
`else
    localparam int PD = 0;
`endif
    localparam int LAT  = 3 + PD;
    localparam int HOLD = 1 + PD;
    localparam int TT   = HOLD + PD + 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    lock_seq_if bus ();

    always #5 clk = ~clk;

    lock_seq_ctrl #(
        .MAX_FAIL(3), .LOCK_CYCLES(LOCK_T), .OPEN_CYCLES(OPEN_T), .DEB_CYCLES(DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [1:0] store [8] = '{default: 2'd0};
    logic [2:0] cur_len_m = 3'd4;
    logic [2:0] wr_i_log [8] = '{default: 3'd0};
    logic [1:0] wr_d_log [8] = '{default: 2'd0};
    int wr_cnt = 0;
    int len_cnt = 0;

    assign bus.rd_digit = store[bus.rd_idx];
    assign bus.cur_len  = cur_len_m;

    always @(posedge clk) begin
        if (bus.wr_en) begin
            store[bus.wr_idx]       <= bus.wr_digit;
            wr_i_log[wr_cnt[2:0]]   <= bus.wr_idx;
            wr_d_log[wr_cnt[2:0]]   <= bus.wr_digit;
            wr_cnt                  <= wr_cnt + 1;
        end
        if (bus.len_wr) begin
            cur_len_m <= bus.new_len;
            len_cnt   <= len_cnt + 1;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // m = {lock_req, change_req, confirm, keypress}
    task automatic press(input logic [3:0] m, input logic [1:0] k);
        bus.key = k;
        {bus.lock_req, bus.change_req, bus.confirm, bus.keypress} = m;
        tick(HOLD);
        {bus.lock_req, bus.change_req, bus.confirm, bus.keypress} = 4'b0000;
        tick(PD + 4);
    endtask

    task automatic key(input logic [1:0] k);
        press(4'b0001, k);
    endtask

    task automatic conf();
        press(4'b0010, 2'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key = 2'd0;
        {bus.lock_req, bus.change_req, bus.confirm, bus.keypress} = 4'b0000;
        rst_n = 1'b0;
        tick(3);
        check("rst_unlocked", bus.unlocked, 0);
        check("rst_prog", bus.prog_mode, 0);
        check("rst_alarm", bus.alarm, 0);
        check("rst_fail", bus.fail_cnt, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_len_wr", bus.len_wr, 0);
        check("rst_rd_idx", bus.rd_idx, 0);
        rst_n = 1'b1;
        tick(1);

`ifdef LOCK_DEBOUNCE_EN
        bus.keypress = 1'b1;
        tick(5);
        bus.keypress = 1'b0;
        tick(PD + 6);
        check("glitch_no_compare", bus.rd_idx, 0);
`endif

        // correct code 0,0,0,0 with exact confirm-to-unlock latency
        repeat (4) key(2'd0);
        check("idx_after_4", bus.rd_idx, 4);
        bus.confirm = 1'b1;
        tick(HOLD);
        bus.confirm = 1'b0;
        tick(LAT - 1 - HOLD);
        check("unlock_early", bus.unlocked, 0);
        tick(1);
        check("unlock_on_time", bus.unlocked, 1);
        tick(TT - LAT);
        check("unlock_fail_cnt", bus.fail_cnt, 0);
        press(4'b1000, 2'd0);
        check("lock_req_relock", bus.unlocked, 0);

        // three wrong codes lead to lockout
        for (int a = 1; a <= 2; a++) begin
            key(2'd0); key(2'd1); key(2'd0); key(2'd0);
            conf();
            check("wrong_fail_cnt", bus.fail_cnt, a);
            check("wrong_locked", bus.unlocked, 0);
        end
        key(2'd0); key(2'd1); key(2'd0); key(2'd0);
        conf();
        check("lockout_alarm", bus.alarm, 1);
        check("lockout_fail_cnt", bus.fail_cnt, 3);
        key(2'd0);
        check("lockout_key_ignored", bus.rd_idx, 0);
        tick(LAT + LOCK_T - 1 - 2 * TT);
        check("lockout_last_cycle", bus.alarm, 1);
        tick(1);
        check("lockout_exit_alarm", bus.alarm, 0);
        check("lockout_exit_fail", bus.fail_cnt, 0);

        // length mismatch: too short, then overflow
        repeat (3) key(2'd0);
        conf();
        check("short_fail", bus.fail_cnt, 1);
        repeat (8) key(2'd0);
        check("idx_saturate", bus.rd_idx, 7);
        conf();
        check("overflow_fail", bus.fail_cnt, 2);
        check("overflow_locked", bus.unlocked, 0);

        repeat (4) key(2'd0);
        conf();
        check("reunlock", bus.unlocked, 1);
        check("reunlock_fail", bus.fail_cnt, 0);

        // program a new 3-digit code 3,2,1
        press(4'b0100, 2'd0);
        check("prog_mode_on", bus.prog_mode, 1);
        check("prog_unlocked", bus.unlocked, 1);
        key(2'd3); key(2'd2); key(2'd1);
        conf();
        check("prog_wr_cnt", wr_cnt, 3);
        check("prog_wr0_idx", wr_i_log[0], 0);
        check("prog_wr0_dat", wr_d_log[0], 3);
        check("prog_wr1_idx", wr_i_log[1], 1);
        check("prog_wr1_dat", wr_d_log[1], 2);
        check("prog_wr2_idx", wr_i_log[2], 2);
        check("prog_wr2_dat", wr_d_log[2], 1);
        check("prog_len_cnt", len_cnt, 1);
        check("prog_new_len", cur_len_m, 3);
        check("prog_exit_mode", bus.prog_mode, 0);
        check("prog_exit_open", bus.unlocked, 1);

        // idle timeout in OPEN
        tick(LAT + OPEN_T - 1 - TT);
        check("idle_last_cycle", bus.unlocked, 1);
        tick(1);
        check("idle_relock", bus.unlocked, 0);

        // the new code opens the lock
        key(2'd3); key(2'd2); key(2'd1);
        conf();
        check("new_code_unlock", bus.unlocked, 1);

        // lock_req beats a simultaneous key press in PROGRAM
        press(4'b0100, 2'd0);
        press(4'b1001, 2'd2);
        check("sim_lock_unlocked", bus.unlocked, 0);
        check("sim_lock_prog", bus.prog_mode, 0);
        check("sim_lock_no_wr", wr_cnt, 3);

        // reset in the middle of a PROGRAM confirm
        key(2'd3); key(2'd2); key(2'd1);
        conf();
        press(4'b0100, 2'd0);
        key(2'd0);
        check("pre_rst_wr_cnt", wr_cnt, 4);
        bus.confirm = 1'b1;
        tick(HOLD);
        bus.confirm = 1'b0;
        tick(LAT - 1 - HOLD);
        rst_n = 1'b0;
        #1;
        check("rst_mid_unlocked", bus.unlocked, 0);
        check("rst_mid_prog", bus.prog_mode, 0);
        check("rst_mid_rd_idx", bus.rd_idx, 0);
        tick(3);
        check("rst_mid_no_len_wr", len_cnt, 1);
        check("rst_mid_write_stands", store[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
